// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator.
// The 2-bit state width matches the detector family's state output.
package seq_pkg;

    localparam int SEQ_STATE_W = 2;
    localparam logic SEQ_IDLE_LEVEL_DEFAULT = 1'b1;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_SHIFT = 2'd1,
        SEQ_GAP   = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_generator.sv
// Serial bit-pattern transmitter: captures a pattern on start and shifts it out
// MSB-first, optionally repeating with an idle gap, then pulses o_done.
module seq_generator
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter int   REP_W      = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = SEQ_IDLE_LEVEL_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_pattern,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [REP_W-1:0]       i_repeat,
    output logic                   o_seq,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [SEQ_STATE_W-1:0] state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e       r_state, w_state_n;
    logic [WIDTH-1:0] r_pattern, w_pattern_n;
    logic [IDX_W-1:0] r_idx, w_idx_n;
    logic [IDX_W-1:0] r_last, w_last_n;
    logic [GAP_W-1:0] r_gap, w_gap_n;
    logic [REP_W-1:0] r_rep, w_rep_n;
    logic [LEN_W-1:0] w_len_eff;
    logic             r_seq, r_valid, r_busy, r_done;

    // r_rep holds the transmissions still owed after the current one.
    always_comb begin
        w_state_n   = r_state;
        w_pattern_n = r_pattern;
        w_idx_n     = r_idx;
        w_last_n    = r_last;
        w_gap_n     = r_gap;
        w_rep_n     = r_rep;
        w_len_eff   = (i_len > LEN_MAX) ? LEN_MAX : i_len;

        case (r_state)
            SEQ_IDLE: begin
                if (i_start && (i_len != '0)) begin
                    w_state_n   = SEQ_SHIFT;
                    w_pattern_n = i_pattern;
                    w_last_n    = IDX_W'(w_len_eff - LEN_W'(1));
                    w_idx_n     = IDX_W'(w_len_eff - LEN_W'(1));
                    w_rep_n     = (i_repeat == '0) ? '0 : i_repeat - REP_W'(1);
                end
            end
            SEQ_SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_n = r_idx - IDX_W'(1);
                end else if (r_rep != '0) begin
                    w_rep_n = r_rep - REP_W'(1);
                    if (GAP_CYCLES > 0) begin
                        w_state_n = SEQ_GAP;
                        w_gap_n   = GAP_LAST;
                    end else begin
                        w_idx_n = r_last;
                    end
                end else begin
                    w_state_n = SEQ_DONE;
                end
            end
            SEQ_GAP: begin
                if (r_gap == '0) begin
                    w_state_n = SEQ_SHIFT;
                    w_idx_n   = r_last;
                end else begin
                    w_gap_n = r_gap - GAP_W'(1);
                end
            end
            SEQ_DONE: begin
                w_state_n = SEQ_IDLE;
            end
            default: w_state_n = SEQ_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= SEQ_IDLE;
            r_pattern <= '0;
            r_idx     <= '0;
            r_last    <= '0;
            r_gap     <= '0;
            r_rep     <= '0;
            r_seq     <= IDLE_LEVEL;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pattern <= w_pattern_n;
            r_idx     <= w_idx_n;
            r_last    <= w_last_n;
            r_gap     <= w_gap_n;
            r_rep     <= w_rep_n;
            r_seq     <= (w_state_n == SEQ_SHIFT) ? w_pattern_n[w_idx_n] : IDLE_LEVEL;
            r_valid   <= (w_state_n == SEQ_SHIFT);
            r_busy    <= (w_state_n != SEQ_IDLE);
            r_done    <= (w_state_n == SEQ_DONE);
        end
    end

    assign o_seq   = r_seq;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign state   = r_state;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: hand-computed per-cycle expectations,
// sampled on the falling edge.
module tb_seq_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic [7:0] i_pattern;
    logic [3:0] i_len;
    logic [3:0] i_repeat;
    logic       o_seq, o_valid, o_busy, o_done;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    seq_generator #(
        .WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_pattern(i_pattern),
        .i_len(i_len), .i_repeat(i_repeat), .o_seq(o_seq), .o_valid(o_valid),
        .o_busy(o_busy), .o_done(o_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic e_seq, input logic e_valid,
                        input logic e_busy, input logic e_done, input logic [1:0] e_state);
        chk({tag, ".seq"},   32'(o_seq),   32'(e_seq));
        chk({tag, ".valid"}, 32'(o_valid), 32'(e_valid));
        chk({tag, ".busy"},  32'(o_busy),  32'(e_busy));
        chk({tag, ".done"},  32'(o_done),  32'(e_done));
        chk({tag, ".state"}, 32'(state),   32'(e_state));
    endtask

    task automatic step(input string tag, input logic e_seq, input logic e_valid,
                        input logic e_busy, input logic e_done, input logic [1:0] e_state);
        @(negedge clk);
        outs(tag, e_seq, e_valid, e_busy, e_done, e_state);
    endtask

    task automatic send_bits(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step($sformatf("%s.b%0d", tag, i), bits[i], 1'b1, 1'b1, 1'b0, 2'd1);
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; i_start = 1'b0; i_pattern = '0; i_len = '0; i_repeat = '0;
        #1;
        outs("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 1: 3 bits of 8'h04 -> 1,0,0
        i_start = 1'b1; i_pattern = 8'h04; i_len = 4'd3; i_repeat = 4'd1;
        step("t1.b2", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        step("t1.b1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t1.b0", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t1.done", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t1.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 2: 2 bits of 8'h01 twice with a 2-cycle gap
        i_start = 1'b1; i_pattern = 8'h01; i_len = 4'd2; i_repeat = 4'd2;
        step("t2.r0b1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        step("t2.r0b0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t2.gap0", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        step("t2.gap1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        step("t2.r1b1", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t2.r1b0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t2.done", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t2.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 3: inputs churn during SHIFT; start held high through DONE
        i_start = 1'b1; i_pattern = 8'hA5; i_len = 4'd8; i_repeat = 4'd1;
        step("t3.b7", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        i_pattern = 8'h07; i_len = 4'd3; i_repeat = 4'd3;
        pat = 8'hA5;
        for (int i = 6; i >= 0; i--)
            step($sformatf("t3.b%0d", i), pat[i], 1'b1, 1'b1, 1'b0, 2'd1);
        step("t3.done", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t3.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        i_repeat = 4'd1;
        step("t3.restart", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        step("t3.rb1", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t3.rb0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        step("t3.rdone", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t3.ridle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 4: asynchronous reset during the second bit of an all-zero 8-bit pattern
        i_start = 1'b1; i_pattern = 8'h00; i_len = 4'd8; i_repeat = 4'd1;
        step("t4.b7", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        @(posedge clk); #1;
        outs("t4.b6", 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        #1 reset = 1'b1;
        #1;
        outs("t4.async", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++)
            step($sformatf("t4.quiet%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 5: zero length is ignored; oversize length clamps to 8
        i_start = 1'b1; i_pattern = 8'hFF; i_len = 4'd0; i_repeat = 4'd1;
        step("t5.len0a", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step("t5.len0b", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        i_pattern = 8'hC3; i_len = 4'd12;
        step("t5.b7", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        pat = 8'hC3;
        for (int i = 6; i >= 0; i--)
            step($sformatf("t5.b%0d", i), pat[i], 1'b1, 1'b1, 1'b0, 2'd1);
        step("t5.done", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t5.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // 6: repeat of 0 behaves as a single transmission of 1,0,1,0
        i_start = 1'b1; i_pattern = 8'h0A; i_len = 4'd4; i_repeat = 4'd0;
        step("t6.b3", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        i_start = 1'b0;
        send_bits("t6", 8'h0A, 3);
        step("t6.done", 1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        step("t6.idle", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
